// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial add/subtract datapath.
// Latency: none (declarations only).
// Backpressure: not applicable.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_reg.sv
// Parallel-load, shift-right register presenting its LSB as the serial output.
// Latency: load and shift both take effect on the next rising edge.
// Backpressure: none; load has priority over shift.
module piso_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {1'b0, q[WIDTH-1:1]};
        end
    end

    assign sout = q[0];

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial A+B / A-B, one bit per clock, LSB first, with carry and signed overflow.
// Latency: done pulses in the cycle after edge WIDTH, counting the start edge as edge 0.
// Backpressure: start is ignored while busy; it is accepted in DONE for back-to-back use.
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;
    logic             sa_bit;
    logic             sb_bit;
    logic             carry;
    logic             fa_sum;
    logic             fa_carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] sb_load;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    // Subtraction is A + ~B + 1: the +1 comes from seeding the carry with mode.
    assign sb_load = (mode == MODE_ADD) ? B : ~B;

    piso_reg #(.WIDTH(WIDTH)) u_sa (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (step),
        .din   (A),
        .sout  (sa_bit)
    );

    piso_reg #(.WIDTH(WIDTH)) u_sb (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (step),
        .din   (sb_load),
        .sout  (sb_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign fa_sum   = sa_bit ^ sb_bit ^ carry;
    assign fa_carry = (sa_bit & sb_bit) | (carry & (sa_bit ^ sb_bit));
    assign res_nxt  = {fa_sum, res[WIDTH-1:1]};

    // On the MSB step, carry still holds the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry  <= 1'b0;
            cnt    <= '0;
            res    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (load) begin
            carry <= mode;
            cnt   <= '0;
        end else if (step) begin
            carry <= fa_carry;
            cnt   <= cnt + 1'b1;
            res   <= res_nxt;
            if (last) begin
                sum_r  <= res_nxt;
                cout_r <= fa_carry;
                ovf_r  <= carry ^ fa_carry;
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed corner cases plus random operands against an arithmetic model.
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    bit          sel16 = 1'b0;
    logic        start_i = 1'b0;
    logic        mode_i = 1'b0;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;

    logic        start8, start16;
    logic        busy8, done8, cout8, ovf8;
    logic        busy16, done16, cout16, ovf16;
    logic [7:0]  sum8;
    logic [15:0] sum16;
    logic        o_busy, o_done, o_cout, o_ovf;
    logic [15:0] o_sum;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign start8  = start_i & ~sel16;
    assign start16 = start_i & sel16;
    assign o_busy  = sel16 ? busy16 : busy8;
    assign o_done  = sel16 ? done16 : done8;
    assign o_cout  = sel16 ? cout16 : cout8;
    assign o_ovf   = sel16 ? ovf16  : ovf8;
    assign o_sum   = sel16 ? sum16  : {8'h00, sum8};

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .mode  (mode_i),
        .A     (a_i[7:0]),
        .B     (b_i[7:0]),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8),
        .ovf   (ovf8)
    );

    serial_addsub #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .mode  (mode_i),
        .A     (a_i),
        .B     (b_i),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16),
        .ovf   (ovf16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic: wrapped result, unsigned carry/no-borrow, signed range test.
    function automatic void ref_model(input int w, input bit m, input longint a, input longint b,
                                      output longint s, output bit c, output bit v);
        longint mask, lim, sa, sb, ideal, r;
        mask = (longint'(1) << w) - 1;
        lim  = longint'(1) << (w - 1);
        sa   = a[w-1] ? a - (longint'(1) << w) : a;
        sb   = b[w-1] ? b - (longint'(1) << w) : b;
        if (!m) begin
            r     = a + b;
            c     = (r > mask);
            ideal = sa + sb;
        end else begin
            r     = a - b;
            c     = (a >= b);
            ideal = sa - sb;
        end
        s = r & mask;
        v = (ideal >= lim) || (ideal < -lim);
    endfunction

    task automatic run_op(input int w, input bit m, input longint a, input longint b,
                          input bit repulse, input string tag);
        longint es;
        bit     ec, ev;
        int     k, nbusy;
        ref_model(w, m, a, b, es, ec, ev);
        @(negedge clk);
        sel16 = (w == 16); start_i = 1'b1; mode_i = m; a_i = 16'(a); b_i = 16'(b);
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        k = 0; nbusy = 0;
        while (!o_done && k < 40) begin
            if (o_busy) nbusy++;
            if (repulse && k == 2) begin
                start_i = 1'b1; mode_i = ~m; a_i = ~a_i; b_i = 16'h0013;
            end
            if (repulse && k == 3) start_i = 1'b0;
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, k, w);
        check({tag, " busy_cycles"}, nbusy, w);
        check({tag, " sum"}, {16'h0, o_sum}, 32'(es));
        check({tag, " cout"}, o_cout, ec);
        check({tag, " ovf"}, o_ovf, ev);
        @(negedge clk);
        check({tag, " done_one_cycle"}, {o_done, o_busy}, 2'b00);
    endtask

    initial begin
        int k;
        int ndone;
        #1;
        check("reset busy", busy8, 0);
        check("reset done", done8, 0);
        check("reset sum", sum8, 0);
        check("reset cout", cout8, 0);
        check("reset ovf", ovf8, 0);
        check("reset sum16", sum16, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(8, 1'b0, 55, 31, 1'b0, "add55_31");
        run_op(8, 1'b1, 31, 55, 1'b0, "sub31_55");
        run_op(8, 1'b1, 55, 31, 1'b0, "sub55_31");
        run_op(8, 1'b0, 127, 1, 1'b0, "add127_1");
        run_op(8, 1'b0, 255, 1, 1'b0, "add255_1");
        run_op(8, 1'b0, 55, 31, 1'b1, "repulse");
        run_op(16, 1'b1, 0, 1, 1'b0, "w16_sub0_1");

        // Start held high from the first op through its DONE cycle.
        @(negedge clk);
        sel16 = 1'b0; start_i = 1'b1; mode_i = 1'b0; a_i = 16'd55; b_i = 16'd31;
        @(posedge clk);
        @(negedge clk);
        a_i = 16'd7; b_i = 16'd9;
        k = 0;
        while (!o_done && k < 40) begin @(negedge clk); k++; end
        check("held first latency", k, 8);
        check("held first sum", o_sum, 86);
        a_i = 16'd100; b_i = 16'd27;
        @(negedge clk);
        check("held no idle", {o_done, o_busy}, 2'b01);
        k = 1;
        while (!o_done && k < 40) begin @(negedge clk); k++; end
        start_i = 1'b0;
        check("held second gap", k, 9);
        check("held second sum", o_sum, 127);

        // Reset dropped right after edge 4 of an operation.
        @(negedge clk);
        sel16 = 1'b0; start_i = 1'b1; mode_i = 1'b0; a_i = 16'd200; b_i = 16'd100;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset busy", o_busy, 0);
        check("midreset sum", o_sum, 0);
        check("midreset done", o_done, 0);
        check("midreset cout_ovf", {o_cout, o_ovf}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin @(negedge clk); if (o_done) ndone++; end
        check("midreset no_done", ndone, 0);
        run_op(8, 1'b1, 200, 100, 1'b0, "after_reset");

        for (int i = 0; i < 24; i++) begin
            int     w;
            longint a, b;
            bit     m;
            w = ($urandom_range(0, 3) == 0) ? 16 : 8;
            a = longint'($urandom_range(0, (1 << w) - 1));
            b = longint'($urandom_range(0, (1 << w) - 1));
            m = 1'($urandom_range(0, 1));
            run_op(w, m, a, b, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
